// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose:
//   Debug read-side companion to the processor register file. On a start
//   request it walks the register file's debug read port from register 0
//   up to NUM_REGS-1. It serialises each register as DATA_WIDTH/8 bytes,
//   least significant byte first, on a valid/ready byte stream. The core
//   write port is never touched, so a dump does not stall the core.
//
// Parameters:
//   DATA_WIDTH    register width in bits; must be a multiple of 8
//   ADDRESS_WIDTH width of extaddress
//   NUM_REGS      number of registers dumped; at most 2**ADDRESS_WIDTH
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset, aborts any dump in progress
//   start       dump request, only looked at while idle
//   extaddress  debug read address into the register file
//   rdval       debug read data, combinational from extaddress
//   out_data    stream byte
//   out_valid   out_data is valid
//   out_ready   sink accepts the byte when out_valid && out_ready at an edge
//   out_last    final byte of the whole dump, qualified by out_valid
//   busy        high while a dump is in progress (LOAD or SEND)
//   done        one-cycle pulse after the final byte has been accepted
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] extaddress,
  input  logic [DATA_WIDTH-1:0]    rdval,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0]         LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_REGS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]         r_byteCnt;
  logic [DATA_WIDTH-1:0]    r_shift;

  logic w_accept;
  logic w_lastByte;
  logic w_lastReg;

  // Handshake and position decode shared by the FSM and the outputs.
  assign w_accept   = (r_state == S_SEND) && out_ready;
  assign w_lastByte = (r_byteCnt == LAST_BYTE);
  assign w_lastReg  = (r_addr == LAST_ADDR);

  // Main sequencer. The address register only moves on the edge that enters
  // LOAD, so extaddress is steady for the whole LOAD+SEND span of a register.
  // The word is snapshotted at the LOAD edge; later register file writes to
  // that register are not seen, writes to registers not yet loaded are.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_byteCnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
          end
        end
        S_LOAD: begin
          r_shift   <= rdval;
          r_byteCnt <= '0;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            if (!w_lastByte) begin
              r_shift   <= r_shift >> 8;
              r_byteCnt <= r_byteCnt + CNT_W'(1);
            end else if (w_lastReg) begin
              r_state <= S_FIN;
            end else begin
              r_addr  <= r_addr + ADDRESS_WIDTH'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free
  // with respect to out_ready and hold steady while the sink stalls.
  assign extaddress = r_addr;
  assign out_valid  = (r_state == S_SEND);
  assign out_data   = out_valid ? r_shift[7:0] : 8'h00;
  assign out_last   = out_valid && w_lastByte && w_lastReg;
  assign busy       = (r_state == S_LOAD) || (r_state == S_SEND);
  assign done       = (r_state == S_FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Purpose:
//   Self-checking bench for regfile_dump_reader at default parameters. It
//   models the register file as an array feeding rdval combinationally.
//   Expected bytes are pushed to a scoreboard queue when a dump is requested.
//   Captured stream bytes are popped against it by each scenario task.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  extaddress;
  logic [31:0] rdval;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [31:0] expWords [32];

  logic [7:0] expQ [$];
  logic [7:0] gotData [$];
  logic       gotLast [$];

  int   errors;
  int   checks;
  int   doneCount;
  int   doneCycle;
  int   stallBad;
  logic busyAtDone;
  logic postBusy [5];
  logic [4:0] postAddr [5];
  bit   stoppedAtByte;

  regfile_dump_reader #(
    .DATA_WIDTH(32),
    .ADDRESS_WIDTH(5),
    .NUM_REGS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .extaddress(extaddress),
    .rdval(rdval),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  // The register file debug read port is purely combinational.
  assign rdval = regs[extaddress];

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set the register file model and the expected snapshot to the common
  // pattern: x1 and x31 loaded, everything else zero.
  task automatic setBaseRegs();
    for (int i = 0; i < 32; i++) begin
      regs[i]     = 32'h0;
      expWords[i] = 32'h0;
    end
    regs[1]      = 32'h11223344;
    regs[31]     = 32'hDEADBEEF;
    expWords[1]  = 32'h11223344;
    expWords[31] = 32'hDEADBEEF;
  endtask

  // Scoreboard push: the whole dump, LSB first per register.
  task automatic pushDump();
    expQ.delete();
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 4; b++) begin
        expQ.push_back(expWords[r][8*b +: 8]);
      end
    end
  endtask

  task automatic idleGap(input int n);
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Requests a dump and records the stream. Samples on the falling edge and
  // drives out_ready for the following rising edge. cyc counts cycles after
  // the edge that sampled start, so cyc==1 is the first busy cycle.
  task automatic collectDump(input int readyMode, input int restartAt,
                             input int stopAtByte, input bit doWrite,
                             input bit holdStart, input int maxCycles);
    int cyc;
    int postCnt;
    bit written;
    logic [3:0] readyPat;
    logic [7:0] pData;
    logic pLast, pValid, pReady;
    readyPat = 4'b1001;
    gotData.delete();
    gotLast.delete();
    doneCount = 0;
    doneCycle = -1;
    stallBad = 0;
    busyAtDone = 1'b1;
    stoppedAtByte = 0;
    postCnt = 0;
    written = 0;
    pValid = 1'b0;
    pReady = 1'b0;
    pData = 8'h00;
    pLast = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = holdStart;
    cyc = 1;
    while (cyc <= maxCycles && postCnt < 5) begin
      if (doneCycle >= 0) begin
        postBusy[postCnt] = busy;
        postAddr[postCnt] = extaddress;
        postCnt++;
      end
      if (done === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle  = cyc;
          busyAtDone = busy;
        end
      end
      if (pValid && !pReady &&
          (out_valid !== 1'b1 || out_data !== pData || out_last !== pLast))
        stallBad++;
      if (stopAtByte >= 0 && out_valid === 1'b1 && gotData.size() == stopAtByte) begin
        stoppedAtByte = 1;
        break;
      end
      if (doWrite && !written && out_valid === 1'b1 && extaddress == 5'd2) begin
        regs[5] = 32'hCAFEF00D;
        written = 1;
      end
      out_ready = (readyMode == 0) ? 1'b1 : readyPat[cyc % 4];
      if (restartAt > 0)
        start = (cyc == restartAt - 1) || holdStart;
      if (out_valid === 1'b1 && out_ready && doneCycle < 0) begin
        gotData.push_back(out_data);
        gotLast.push_back(out_last);
      end
      pValid = out_valid;
      pReady = out_ready;
      pData  = out_data;
      pLast  = out_last;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h want=00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got=%b want=0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (extaddress !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr got=%0d want=0", extaddress); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_dump();
    logic [7:0] k [8];
    int lastCount;
    k = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    setBaseRegs();
    pushDump();
    collectDump(0, -1, -1, 0, 0, 400);
    checks++; if (gotData.size() != 128) begin errors++; $display("[TB] FAIL basic_count got=%0d want=128", gotData.size()); end
    for (int i = 0; i < gotData.size() && expQ.size() > 0; i++) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checks++; if (gotData[i] !== e) begin errors++; $display("[TB] FAIL basic_byte%0d got=%h want=%h", i, gotData[i], e); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (gotData[4+i] !== k[i]) begin errors++; $display("[TB] FAIL basic_x1_b%0d got=%h want=%h", i, gotData[4+i], k[i]); end
      checks++; if (gotData[124+i] !== k[4+i]) begin errors++; $display("[TB] FAIL basic_x31_b%0d got=%h want=%h", i, gotData[124+i], k[4+i]); end
    end
    lastCount = 0;
    foreach (gotLast[i]) if (gotLast[i] === 1'b1) lastCount++;
    checks++; if (lastCount != 1) begin errors++; $display("[TB] FAIL basic_last_count got=%0d want=1", lastCount); end
    checks++; if (gotLast[127] !== 1'b1) begin errors++; $display("[TB] FAIL basic_last_pos got=%b want=1", gotLast[127]); end
    checks++; if (doneCycle != 161) begin errors++; $display("[TB] FAIL basic_done_cycle got=%0d want=161", doneCycle); end
    checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done got=%b want=0", busyAtDone); end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL basic_done_pulses got=%0d want=1", doneCount); end
    checks++; if (postBusy[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after got=%b want=0", postBusy[0]); end
    idleGap(3);
  endtask

  task automatic test_stall();
    setBaseRegs();
    pushDump();
    collectDump(1, -1, -1, 0, 0, 1500);
    checks++; if (gotData.size() != 128) begin errors++; $display("[TB] FAIL stall_count got=%0d want=128", gotData.size()); end
    for (int i = 0; i < gotData.size() && expQ.size() > 0; i++) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checks++; if (gotData[i] !== e) begin errors++; $display("[TB] FAIL stall_byte%0d got=%h want=%h", i, gotData[i], e); end
    end
    checks++; if (gotLast[127] !== 1'b1) begin errors++; $display("[TB] FAIL stall_last got=%b want=1", gotLast[127]); end
    checks++; if (stallBad != 0) begin errors++; $display("[TB] FAIL stall_stability got=%0d violations want=0", stallBad); end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL stall_done_pulses got=%0d want=1", doneCount); end
    idleGap(3);
  endtask

  task automatic test_restart_ignored();
    setBaseRegs();
    pushDump();
    collectDump(0, 5, -1, 0, 0, 400);
    checks++; if (gotData.size() != 128) begin errors++; $display("[TB] FAIL restart_count got=%0d want=128", gotData.size()); end
    checks++; if (expQ.size() != 128) begin errors++; $display("[TB] FAIL restart_sb_depth got=%0d want=128", expQ.size()); end
    for (int i = 0; i < gotData.size() && expQ.size() > 0; i++) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checks++; if (gotData[i] !== e) begin errors++; $display("[TB] FAIL restart_byte%0d got=%h want=%h", i, gotData[i], e); end
    end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL restart_done_pulses got=%0d want=1", doneCount); end
    checks++; if (doneCycle != 161) begin errors++; $display("[TB] FAIL restart_done_cycle got=%0d want=161", doneCycle); end
    idleGap(3);
  endtask

  task automatic test_reset_mid_dump();
    int sawDone;
    int sawValid;
    setBaseRegs();
    pushDump();
    collectDump(0, -1, 50, 0, 0, 400);
    checks++; if (!stoppedAtByte) begin errors++; $display("[TB] FAIL midrst_reached got=%0d want=1", stoppedAtByte); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (extaddress !== 5'd0) begin errors++; $display("[TB] FAIL midrst_addr got=%0d want=0", extaddress); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
    rst = 1'b0;
    sawDone = 0;
    sawValid = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) sawDone++;
      if (out_valid === 1'b1) sawValid++;
    end
    checks++; if (sawDone != 0) begin errors++; $display("[TB] FAIL midrst_late_done got=%0d want=0", sawDone); end
    checks++; if (sawValid != 0) begin errors++; $display("[TB] FAIL midrst_late_bytes got=%0d want=0", sawValid); end
    pushDump();
    collectDump(0, -1, -1, 0, 0, 400);
    checks++; if (gotData.size() != 128) begin errors++; $display("[TB] FAIL midrst_redump_count got=%0d want=128", gotData.size()); end
    for (int i = 0; i < gotData.size() && expQ.size() > 0; i++) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checks++; if (gotData[i] !== e) begin errors++; $display("[TB] FAIL midrst_byte%0d got=%h want=%h", i, gotData[i], e); end
    end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL midrst_redump_done got=%0d want=1", doneCount); end
    idleGap(3);
  endtask

  task automatic test_write_during_dump();
    logic [7:0] k [4];
    k = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    setBaseRegs();
    expWords[5] = 32'hCAFEF00D;
    pushDump();
    collectDump(0, -1, -1, 1, 0, 400);
    checks++; if (gotData.size() != 128) begin errors++; $display("[TB] FAIL write_count got=%0d want=128", gotData.size()); end
    for (int i = 0; i < gotData.size() && expQ.size() > 0; i++) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checks++; if (gotData[i] !== e) begin errors++; $display("[TB] FAIL write_byte%0d got=%h want=%h", i, gotData[i], e); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (gotData[20+i] !== k[i]) begin errors++; $display("[TB] FAIL write_x5_b%0d got=%h want=%h", i, gotData[20+i], k[i]); end
    end
    checks++; if (gotData[4] !== 8'h44) begin errors++; $display("[TB] FAIL write_x1_b0 got=%h want=44", gotData[4]); end
    regs[5] = 32'h0;
    idleGap(3);
  endtask

  task automatic test_back_to_back();
    int secondDone;
    int waitCnt;
    setBaseRegs();
    pushDump();
    collectDump(0, -1, -1, 0, 1, 400);
    checks++; if (gotData.size() != 128) begin errors++; $display("[TB] FAIL b2b_count got=%0d want=128", gotData.size()); end
    for (int i = 0; i < gotData.size() && expQ.size() > 0; i++) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checks++; if (gotData[i] !== e) begin errors++; $display("[TB] FAIL b2b_byte%0d got=%h want=%h", i, gotData[i], e); end
    end
    checks++; if (doneCycle != 161) begin errors++; $display("[TB] FAIL b2b_done_cycle got=%0d want=161", doneCycle); end
    checks++; if (postBusy[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_busy got=%b want=0", postBusy[0]); end
    checks++; if (postBusy[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rebusy got=%b want=1", postBusy[1]); end
    checks++; if (postAddr[1] !== 5'd0) begin errors++; $display("[TB] FAIL b2b_addr_restart got=%0d want=0", postAddr[1]); end
    secondDone = 0;
    repeat (170) begin
      if (done === 1'b1) secondDone++;
      @(negedge clk);
    end
    checks++; if (secondDone != 1) begin errors++; $display("[TB] FAIL b2b_second_done got=%0d want=1", secondDone); end
    start = 1'b0;
    waitCnt = 0;
    while ((busy === 1'b1 || done === 1'b1) && waitCnt < 400) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got=%b want=0", busy); end
    idleGap(3);
  endtask

  // Scenario sequence.
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_basic_dump();
    test_stall();
    test_restart_ignored();
    test_reset_mid_dump();
    test_write_during_dump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug read-side companion to the processor register file: on request, walks the register file's external debug read port (extaddress/rdval) from register 0 to NUM_REGS-1.
- Serializes each register as DATA_WIDTH/8 bytes, LSB first, on a valid/ready byte stream toward the debug/UART path.
- Lets the bench or host dump architectural state without stalling the core write port.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 5, width of extaddress.
- NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1; must be at most 2^ADDRESS_WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  dump request; sampled only while idle.
- extaddress  output  ADDRESS_WIDTH  register file debug read address.
- rdval  input  DATA_WIDTH  register file debug read data; combinational from extaddress.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the byte when out_valid && out_ready at a rising edge.
- out_last  output  1  marks the final byte of the dump, qualified by out_valid.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (rst=1 at an edge) values for the next cycle:
  - All outputs are 0 (out_valid, out_data, out_last, busy, done, extaddress).
  - FSM goes to IDLE; address counter and byte counter are 0.
  - Reset mid-dump aborts the dump immediately: no done pulse and no further bytes.
- FSM states:
  - IDLE: waits for start.
  - LOAD: extaddress holds the current address; rdval settles this cycle.
  - SEND: transmits the captured word.
  - FIN: emits the done pulse.
- IDLE -> LOAD: start=1 at edge T. Cycle T+1: busy=1, extaddress=0, out_valid=0.
- LOAD -> SEND: at the LOAD edge, rdval is captured into a DATA_WIDTH shift register and the byte counter is cleared.
  - In the next cycle, out_valid=1 and out_data=captured[7:0].
- SEND handshake:
  - While out_valid && !out_ready, out_data and out_last hold stable and out_valid stays 1. No retraction.
  - On accept of a byte other than the word's last byte, shift right by 8 and increment the byte counter. The next byte appears in the next cycle, so there are no bubbles inside a word.
  - On accept of byte DATA_WIDTH/8-1:
    - If address < NUM_REGS-1: increment the address, go to LOAD, out_valid=0 for that one cycle.
    - Else: go to FIN.
- out_last = 1 only while presenting the last byte of register NUM_REGS-1.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the FIN cycle is ignored.
- start while busy or in FIN is ignored. start held high in IDLE begins a new dump every time IDLE is re-entered.
- extaddress changes only at the LOAD entry edge and is stable for the whole LOAD and SEND duration of a register.
- Consistency: each word is a snapshot of rdval at its LOAD edge. Register file writes to already-captured registers are not reflected. Writes to not-yet-loaded registers are. No cross-register atomicity.
- Timing with out_ready held at 1, start sampled at edge T, W = DATA_WIDTH/8:
  - Register k bytes appear in cycles T+2+(W+1)k .. T+1+W+(W+1)k.
  - done pulses in cycle T+2+(W+1)NUM_REGS-1.
  - Default parameters: bytes for register 31 in T+157..T+160; done at T+161.
- Total bytes per dump: NUM_REGS*DATA_WIDTH/8, 128 at defaults.

Test Plan:
- Reset, then preload x1=0x11223344, x31=0xDEADBEEF, others 0; pulse start, out_ready=1.
  -> 128 bytes.
  -> Bytes 4..7 = 44,33,22,11.
  -> Bytes 124..127 = EF,BE,AD,DE, with out_last only on byte 127.
  -> done single pulse at T+161; busy low at T+161.
- Same dump with out_ready toggling 1,0,0,1 pattern.
  -> Identical byte sequence.
  -> out_data/out_last stable across every stalled cycle; out_valid never drops while unaccepted.
- Pulse start again at T+5 during a dump.
  -> Ignored; exactly 128 bytes and one done pulse.
- Assert rst at the cycle presenting byte 50.
  -> Next cycle out_valid=0, busy=0, extaddress=0, no done.
  -> A new start after release yields a full 128-byte dump.
- Write x5=0xCAFEF00D via the register file write port while register 2 is being sent.
  -> Bytes 20..23 = 0D,F0,FE,CA.
  -> Register 1 bytes unchanged from the pre-write value.
- Hold start=1 continuously.
  -> Back-to-back dumps, each ending in one done pulse.
  -> Next dump's busy rises the cycle after IDLE is re-entered; extaddress restarts at 0.
